// File: rtl/weight_stream_ctrl.sv
// -----------------------------------------------------------------------------
// weight_stream_ctrl
//
// Purpose:
//   Sequencing controller for a parameter ROM with a fixed read latency.
//   It owns the ROM address and chip-enable and runs a programmed number of
//   full passes over the ROM. Returned words land in a small credit-managed
//   FIFO, so downstream back-pressure never drops or duplicates a word.
//
// Optional feature (macro WEIGHT_STREAM_LAST_EN):
//   When defined, adds output data_out_last, high with the FIFO head word that
//   was read from address DEPTH-1 (the final word of every pass). The flag
//   rides through the valid shift register and the FIFO as an extra bit.
//   When undefined, the port and the extra storage bit are absent.
//
// Ports:
//   clk            in   sole clock, rising edge
//   rst            in   synchronous active-high reset
//   start          in   begin a run (sampled in IDLE only)
//   num_passes     in   passes to run, sampled with start
//   busy           out  high from the cycle after an accepted start to done
//   done           out  one-cycle pulse when the last word is accepted
//   rom_addr       out  ROM address
//   rom_ce         out  ROM enable (1 from the first cycle after reset)
//   rom_q          in   ROM read data
//   data_out       out  FIFO head word
//   data_out_valid out  FIFO non-empty
//   data_out_last  out  head word is the last of a pass (macro only)
//   data_out_ready in   consumer accepts the head word
// -----------------------------------------------------------------------------
module weight_stream_ctrl #(
    parameter int DATA_WIDTH  = 128,
    parameter int DEPTH       = 2304,
    parameter int ADDR_WIDTH  = $clog2(DEPTH) + 1,
    parameter int ROM_LATENCY = 2,
    parameter int PASS_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PASS_WIDTH-1:0] num_passes,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_ce,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
`ifdef WEIGHT_STREAM_LAST_EN
    output logic                  data_out_last,
`endif
    input  logic                  data_out_ready
);

    localparam int FIFO_DEPTH = ROM_LATENCY + 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    // Wide enough for inflight + occupancy, which never exceeds FIFO_DEPTH.
    localparam int CNT_W      = $clog2(FIFO_DEPTH + ROM_LATENCY + 1) + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [PASS_WIDTH-1:0]   r_pass;
    logic [PASS_WIDTH-1:0]   r_num;
    logic                    r_zero_hold;
    logic                    r_ce;
    logic [ROM_LATENCY-1:0]  r_vsr;
    logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [CNT_W-1:0]        r_count;
`ifdef WEIGHT_STREAM_LAST_EN
    logic [ROM_LATENCY-1:0]  r_vsr_last;
    logic                    r_mem_last [FIFO_DEPTH];
`endif

    // ------------------------------------------------------------------
    // Wires
    // ------------------------------------------------------------------
    state_t                  w_state_next;
    logic                    w_issue;
    logic                    w_done;
    logic                    w_load;
    logic                    w_zero_start;
    logic                    w_pop;
    logic                    w_wr;
    logic                    w_room;
    logic                    w_last_addr;
    logic                    w_final_pass;
    logic                    w_fifo_emptying;
    logic [CNT_W-1:0]        w_inflight;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign w_pop        = (r_count != '0) && data_out_ready;
    // The oldest valid bit marks the cycle in which rom_q holds issued data.
    assign w_wr         = r_vsr[ROM_LATENCY-1];
    assign w_last_addr  = (r_addr == LAST_ADDR);
    assign w_final_pass = (r_pass == (r_num - PASS_WIDTH'(1)));

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < ROM_LATENCY; i++) begin
            w_inflight = w_inflight + CNT_W'(r_vsr[i]);
        end
    end

    // Credit check: every issued read already owns a FIFO slot, and a pop in
    // this cycle frees one, so the FIFO can never overflow.
    assign w_room = ((w_inflight + r_count - CNT_W'(w_pop)) < CNT_W'(FIFO_DEPTH));

    // FIFO empties this cycle (empty already, or the single word is popped).
    assign w_fifo_emptying = (r_count == '0) ||
                             ((r_count == CNT_W'(1)) && w_pop);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_done       = 1'b0;
        w_load       = 1'b0;
        w_zero_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (num_passes != '0) begin
                        w_load       = 1'b1;
                        w_state_next = S_STREAM;
                    end else begin
                        w_zero_start = 1'b1;
                        w_state_next = S_DRAIN;
                    end
                end
            end
            S_STREAM: begin
                if (w_room) begin
                    w_issue = 1'b1;
                    if (w_last_addr && w_final_pass) begin
                        w_state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // The zero-pass run spends one extra cycle here so done
                // lands one cycle after entry rather than on entry.
                if (!r_zero_hold && (w_inflight == '0) && w_fifo_emptying) begin
                    w_done       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address / pass counters and ROM enable
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_pass      <= '0;
            r_num       <= '0;
            r_zero_hold <= 1'b0;
            r_ce        <= 1'b0;
        end else begin
            // The ROM pipeline advances every cycle; validity is tracked
            // solely by the shift register.
            r_ce        <= 1'b1;
            r_zero_hold <= w_zero_start;
            if (w_load) begin
                r_num  <= num_passes;
                r_addr <= '0;
                r_pass <= '0;
            end else if (w_issue) begin
                if (w_last_addr) begin
                    r_addr <= '0;
                    r_pass <= r_pass + PASS_WIDTH'(1);
                end else begin
                    r_addr <= r_addr + ADDR_WIDTH'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read-valid shift register, aligned with the ROM latency
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsr <= '0;
        end else begin
            r_vsr[0] <= w_issue;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                r_vsr[i] <= r_vsr[i-1];
            end
        end
    end

`ifdef WEIGHT_STREAM_LAST_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsr_last <= '0;
        end else begin
            r_vsr_last[0] <= w_issue && w_last_addr;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                r_vsr_last[i] <= r_vsr_last[i-1];
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Output FIFO. The head entry is read straight from storage registers,
    // so data_out has no combinational dependence on data_out_ready.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= rom_q;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef WEIGHT_STREAM_LAST_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_last[i] <= 1'b0;
            end
        end else if (w_wr) begin
            r_mem_last[r_wr_ptr] <= r_vsr_last[ROM_LATENCY-1];
        end
    end
    assign data_out_last = r_mem_last[r_rd_ptr];
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_wr && (r_count == CNT_W'(FIFO_DEPTH))));

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy           = (r_state != S_IDLE);
    assign done           = w_done;
    assign rom_addr       = r_addr;
    assign rom_ce         = r_ce;
    assign data_out       = r_mem[r_rd_ptr];
    assign data_out_valid = (r_count != '0);

endmodule

// File: tb/tb_weight_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_weight_stream_ctrl
//
// Drives weight_stream_ctrl (DEPTH=8) against a 2-cycle ROM model whose word i
// equals i. Expected words are queued when a run is started and compared with
// the words accepted on the output handshake.
// -----------------------------------------------------------------------------
module tb_weight_stream_ctrl;

    localparam int DW    = 128;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH) + 1;
    localparam int LAT   = 2;
    localparam int PW    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [PW-1:0] num_passes = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] rom_addr;
    logic          rom_ce;
    logic [DW-1:0] rom_q;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic          data_out_ready = 1'b0;
    logic          last_obs;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t sb_q[$];
    exp_t got_q[$];
    int   checks = 0;
    int   errors = 0;

    weight_stream_ctrl #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .ROM_LATENCY(LAT),
        .PASS_WIDTH (PW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num_passes    (num_passes),
        .busy          (busy),
        .done          (done),
        .rom_addr      (rom_addr),
        .rom_ce        (rom_ce),
        .rom_q         (rom_q),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
`ifdef WEIGHT_STREAM_LAST_EN
        .data_out_last (last_obs),
`endif
        .data_out_ready(data_out_ready)
    );

`ifndef WEIGHT_STREAM_LAST_EN
    assign last_obs = 1'b0;
`endif

    always #5 clk = ~clk;

    // Two-stage ROM model: address register, then data register.
    logic [AW-1:0] rom_s1 = '0;
    logic [DW-1:0] rom_qr = '0;
    always @(posedge clk) begin
        if (rom_ce) begin
            rom_s1 <= rom_addr;
            rom_qr <= DW'(rom_s1);
        end
    end
    assign rom_q = rom_qr;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one cycle and queues the words the run should deliver.
    task automatic do_start(input int np);
        exp_t e;
        start      = 1'b1;
        num_passes = PW'(np);
        for (int p = 0; p < np; p++) begin
            for (int w = 0; w < DEPTH; w++) begin
                e.data = DW'(w);
`ifdef WEIGHT_STREAM_LAST_EN
                e.last = (w == DEPTH - 1);
`else
                e.last = 1'b0;
`endif
                sb_q.push_back(e);
            end
        end
        next_cycle();
        start = 1'b0;
    endtask

    // Observation only: steps n_cyc cycles, collects accepted words into
    // got_q and reports done pulses, peak inflight+occupancy and hold glitches.
    task automatic run_stream(input int n_cyc, input int mode,
                              output int done_cnt, output int done_t,
                              output int max_occ, output int hold_bad);
        exp_t          g;
        logic [AW-1:0] prev_addr;
        int            issued;
        int            popn;
        logic          held_v;
        logic [DW-1:0] held_d;
        done_cnt  = 0;
        done_t    = -1;
        max_occ   = 0;
        hold_bad  = 0;
        issued    = 0;
        popn      = 0;
        held_v    = 1'b0;
        held_d    = '0;
        prev_addr = rom_addr;
        for (int t = 1; t <= n_cyc; t++) begin
            if (mode == 1) begin
                data_out_ready = (((t - 1) % 4) == 0) || (((t - 1) % 4) == 3);
            end else begin
                data_out_ready = 1'b1;
            end
            @(negedge clk);
            if (rom_addr !== prev_addr) issued++;
            prev_addr = rom_addr;
            if (issued - popn > max_occ) max_occ = issued - popn;
            if (held_v && data_out_valid && (data_out !== held_d)) hold_bad++;
            if (done) begin
                done_cnt++;
                if (done_t < 0) done_t = t;
            end
            if (data_out_valid && data_out_ready) begin
                g.data = data_out;
                g.last = last_obs;
                got_q.push_back(g);
                popn++;
            end
            held_v = data_out_valid && !data_out_ready;
            held_d = data_out;
            next_cycle();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) next_cycle();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (rom_addr !== '0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", rom_addr); end
        checks++; if (rom_ce !== 1'b0) begin errors++; $display("FAIL reset_ce got=%b exp=0", rom_ce); end
        checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", data_out_valid); end
        checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data got=%0h exp=0", data_out); end
        checks++; if (last_obs !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", last_obs); end
        next_cycle();
        rst = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++; if (rom_ce !== 1'b1) begin errors++; $display("FAIL ce_after_reset got=%b exp=1", rom_ce); end
        next_cycle();
        $display("test_reset complete");
    endtask

    task automatic test_single();
        exp_t g;
        exp_t e;
        data_out_ready = 1'b1;
        do_start(1);
        for (int t = 1; t <= 13; t++) begin
            @(negedge clk);
            checks++; if (busy !== 1'((t <= 11))) begin errors++; $display("FAIL single_busy t=%0d got=%b", t, busy); end
            checks++; if (done !== 1'((t == 11))) begin errors++; $display("FAIL single_done t=%0d got=%b", t, done); end
            checks++; if (data_out_valid !== 1'((t >= 4) && (t <= 11))) begin
                errors++; $display("FAIL single_valid t=%0d got=%b", t, data_out_valid);
            end
            if (t == 1) begin
                checks++; if (rom_addr !== '0) begin errors++; $display("FAIL single_first_addr got=%0d exp=0", rom_addr); end
            end
            if (data_out_valid && data_out_ready) begin
                g.data = data_out;
                g.last = last_obs;
                got_q.push_back(g);
            end
            next_cycle();
        end
        checks++; if (got_q.size() != DEPTH) begin errors++; $display("FAIL single_count got=%0d exp=%0d", got_q.size(), DEPTH); end
        while (got_q.size() > 0 && sb_q.size() > 0) begin
            g = got_q.pop_front();
            e = sb_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL single_word got=%0d/%b exp=%0d/%b", g.data, g.last, e.data, e.last); end
            else $display("single word %0d last=%b", g.data, g.last);
        end
        got_q.delete();
        sb_q.delete();
    endtask

    task automatic test_toggle();
        int dc, dt, mo, hb;
        exp_t g;
        exp_t e;
        data_out_ready = 1'b1;
        do_start(1);
        run_stream(60, 1, dc, dt, mo, hb);
        checks++; if (dc != 1) begin errors++; $display("FAIL toggle_done_count got=%0d exp=1", dc); end
        checks++; if (mo > 4) begin errors++; $display("FAIL toggle_occupancy got=%0d exp<=4", mo); end
        checks++; if (hb != 0) begin errors++; $display("FAIL toggle_hold got=%0d exp=0", hb); end
        checks++; if (got_q.size() != DEPTH) begin errors++; $display("FAIL toggle_count got=%0d exp=%0d", got_q.size(), DEPTH); end
        while (got_q.size() > 0 && sb_q.size() > 0) begin
            g = got_q.pop_front();
            e = sb_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL toggle_word got=%0d/%b exp=%0d/%b", g.data, g.last, e.data, e.last); end
            else $display("toggle word %0d last=%b", g.data, g.last);
        end
        got_q.delete();
        sb_q.delete();
    endtask

    task automatic test_multi();
        int dc, dt, mo, hb;
        exp_t g;
        exp_t e;
        data_out_ready = 1'b1;
        do_start(3);
        run_stream(40, 0, dc, dt, mo, hb);
        checks++; if (dc != 1) begin errors++; $display("FAIL multi_done_count got=%0d exp=1", dc); end
        checks++; if (dt != 3 + 3 * DEPTH) begin errors++; $display("FAIL multi_done_time got=%0d exp=%0d", dt, 3 + 3 * DEPTH); end
        checks++; if (got_q.size() != 3 * DEPTH) begin errors++; $display("FAIL multi_count got=%0d exp=%0d", got_q.size(), 3 * DEPTH); end
        while (got_q.size() > 0 && sb_q.size() > 0) begin
            g = got_q.pop_front();
            e = sb_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL multi_word got=%0d/%b exp=%0d/%b", g.data, g.last, e.data, e.last); end
            else $display("multi word %0d last=%b", g.data, g.last);
        end
        got_q.delete();
        sb_q.delete();
    endtask

    task automatic test_zero_passes();
        int dc, dt, mo, hb;
        data_out_ready = 1'b1;
        start      = 1'b1;
        num_passes = '0;
        next_cycle();
        // Second start at T+1 with a nonzero count must be ignored.
        start      = 1'b1;
        num_passes = PW'(1);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy_t1 got=%b exp=1", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_t1 got=%b exp=0", done); end
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done_t2 got=%b exp=1", done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy_t2 got=%b exp=1", busy); end
        next_cycle();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_t3 got=%b exp=0", busy); end
        next_cycle();
        run_stream(12, 0, dc, dt, mo, hb);
        checks++; if (dc != 0) begin errors++; $display("FAIL zero_extra_done got=%0d exp=0", dc); end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL zero_words got=%0d exp=0", got_q.size()); end
        checks++; if (rom_addr !== '0) begin errors++; $display("FAIL zero_addr got=%0d exp=0", rom_addr); end
        $display("zero-pass run: done pulses after=%0d words=%0d", dc, got_q.size());
        got_q.delete();
    endtask

    task automatic test_stall();
        int dc, dt, mo, hb;
        exp_t g;
        exp_t e;
        data_out_ready = 1'b0;
        do_start(1);
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            next_cycle();
        end
        checks++; if (rom_addr !== AW'(4)) begin errors++; $display("FAIL stall_issued got=%0d exp=4", rom_addr); end
        checks++; if (data_out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got=%b exp=1", data_out_valid); end
        checks++; if (data_out !== '0) begin errors++; $display("FAIL stall_head got=%0d exp=0", data_out); end
        run_stream(20, 0, dc, dt, mo, hb);
        checks++; if (dc != 1) begin errors++; $display("FAIL stall_done_count got=%0d exp=1", dc); end
        checks++; if (dt != 8) begin errors++; $display("FAIL stall_done_time got=%0d exp=8", dt); end
        checks++; if (got_q.size() != DEPTH) begin errors++; $display("FAIL stall_count got=%0d exp=%0d", got_q.size(), DEPTH); end
        while (got_q.size() > 0 && sb_q.size() > 0) begin
            g = got_q.pop_front();
            e = sb_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL stall_word got=%0d/%b exp=%0d/%b", g.data, g.last, e.data, e.last); end
            else $display("stall word %0d last=%b", g.data, g.last);
        end
        got_q.delete();
        sb_q.delete();
    endtask

    task automatic test_mid_reset();
        int dc, dt, mo, hb;
        exp_t g;
        exp_t e;
        data_out_ready = 1'b1;
        do_start(1);
        for (int t = 0; t < 30 && got_q.size() < 5; t++) begin
            @(negedge clk);
            if (data_out_valid && data_out_ready) begin
                g.data = data_out;
                g.last = last_obs;
                got_q.push_back(g);
            end
            next_cycle();
        end
        data_out_ready = 1'b0;
        checks++; if (got_q.size() != 5) begin errors++; $display("FAIL midrst_pre_count got=%0d exp=5", got_q.size()); end
        while (got_q.size() > 0 && sb_q.size() > 0) begin
            g = got_q.pop_front();
            e = sb_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL midrst_word got=%0d exp=%0d", g.data, e.data); end
            else $display("pre-reset word %0d", g.data);
        end
        sb_q.delete();
        got_q.delete();
        repeat (2) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", done); end
        checks++; if (rom_addr !== '0) begin errors++; $display("FAIL midrst_addr got=%0d exp=0", rom_addr); end
        checks++; if (rom_ce !== 1'b0) begin errors++; $display("FAIL midrst_ce got=%b exp=0", rom_ce); end
        checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", data_out_valid); end
        checks++; if (data_out !== '0) begin errors++; $display("FAIL midrst_data got=%0h exp=0", data_out); end
        next_cycle();
        data_out_ready = 1'b1;
        do_start(1);
        run_stream(20, 0, dc, dt, mo, hb);
        checks++; if (dc != 1) begin errors++; $display("FAIL restart_done_count got=%0d exp=1", dc); end
        checks++; if (dt != 11) begin errors++; $display("FAIL restart_done_time got=%0d exp=11", dt); end
        checks++; if (got_q.size() != DEPTH) begin errors++; $display("FAIL restart_count got=%0d exp=%0d", got_q.size(), DEPTH); end
        while (got_q.size() > 0 && sb_q.size() > 0) begin
            g = got_q.pop_front();
            e = sb_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL restart_word got=%0d/%b exp=%0d/%b", g.data, g.last, e.data, e.last); end
            else $display("restart word %0d last=%b", g.data, g.last);
        end
        got_q.delete();
        sb_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_toggle();
        test_multi();
        test_zero_passes();
        test_stall();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/weight_stream_ctrl.md
# weight_stream_ctrl

Sequencing controller for a parameter ROM with fixed 2-cycle read latency, such as the per-layer `*_weight_rom` instances. It owns the ROM address and chip-enable and runs a programmed number of full passes over the ROM. Returned words are buffered in a small credit-managed FIFO, so downstream back-pressure never loses or duplicates a word. The block sits between the ROM and the dataflow consumer (linear/matmul input), replacing a free-running address counter whose valid is held constant.

## Interface
- `DATA_WIDTH`, 128, ROM word width.
- `DEPTH`, 2304, words per pass; ≥2.
- `ADDR_WIDTH`, `$clog2(DEPTH)+1`, ROM address width.
- `ROM_LATENCY`, 2, ROM cycles from address to data.
- `PASS_WIDTH`, 8, width of pass count.
- Localparam `FIFO_DEPTH` = `ROM_LATENCY+2`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `num_passes`  in  PASS_WIDTH  passes to run; sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` through the `done` cycle.
- `done`  out  1  one-cycle pulse when the last word of the run has been accepted downstream.
- `rom_addr`  out  ADDR_WIDTH  ROM address.
- `rom_ce`  out  1  ROM enable.
- `rom_q`  in  DATA_WIDTH  ROM read data.
- `data_out`  out  DATA_WIDTH  FIFO head word.
- `data_out_valid`  out  1  FIFO non-empty.
- `data_out_ready`  in  1  consumer accepts.

## Operation
- States: IDLE, STREAM, DRAIN.
- IDLE:
  - `start`=1 with `num_passes`≠0 latches the count, clears address and pass counters, and moves to STREAM.
  - `start`=1 with `num_passes`=0 moves to DRAIN. No reads are issued, and `done` pulses the next cycle.
- Issue rule in STREAM: issue one read per cycle when `inflight + occupancy − pop < FIFO_DEPTH`.
  - `inflight` = issued reads whose data has not yet landed.
  - `pop` = `data_out_valid & data_out_ready` in the same cycle.
  - An issue drives `rom_addr` = current address and sets bit 0 of a `ROM_LATENCY`-deep valid shift register. A valid bit reaching the end writes `rom_q` into the FIFO.
- `rom_ce` is held 1 at all times after reset. The ROM pipeline therefore advances every cycle, and the shift register alone tracks validity.
- Address wrap:
  - Address increments 0…DEPTH−1, then wraps to 0 and increments the pass counter.
  - Issuing address DEPTH−1 of the final pass moves the FSM to DRAIN.
- DRAIN:
  - Exits to IDLE when `inflight`=0, FIFO is empty, and no write is pending.
  - `done` pulses in that exit cycle, coincident with the last pop, or one cycle after entry for the zero-pass case.
- `start` while `busy` is ignored. `num_passes` changes mid-run have no effect.
- FIFO overflow is impossible by construction. Implement an assertion that a write to a full FIFO never occurs.
- Pop on an empty FIFO is ignored.
- Simultaneous FIFO write and pop are both performed, and occupancy is unchanged.

## Timing
- Reset values: `busy`=0, `done`=0, `rom_addr`=0, `rom_ce`=0 (1 from the first post-reset cycle), `data_out_valid`=0, `data_out`=0. State is IDLE, and all counters, the shift register and the FIFO are cleared.
- `rst` mid-run aborts immediately: FIFO flushed, in-flight ROM data discarded, no `done` pulse.
- `start` accepted in cycle T:
  - `busy`=1 and `rom_addr`=0 issued in T+1.
  - `rom_q` is captured at the end of T+3.
  - `data_out_valid`=1 in T+4.
- With `data_out_ready` held 1, throughput is one word per cycle with no bubbles.
- A run of P passes completes with `done` in cycle T+3+P·DEPTH.
- `data_out` and `data_out_valid` come from registers, with no combinational path from `data_out_ready`. Once valid, a word holds stable until popped.

## Configuration
- `WEIGHT_STREAM_LAST_EN`
  - Defined: adds output `data_out_last` (1 bit, reset 0). It is high alongside `data_out_valid` for the FIFO word that was read from address DEPTH−1, i.e. the final word of every pass. It is carried through the shift register and FIFO as an extra bit.
  - Undefined: the port and the extra storage bit are absent, and behaviour is otherwise identical.

## Test plan
- DEPTH=8, ROM word i = i, `num_passes`=1, ready=1:
  - Words 0..7 appear on `data_out` in consecutive cycles T+4..T+11.
  - `done` pulses at T+11; `busy` falls at T+12.
- Same configuration, ready toggling 1,0,0,1 repeatedly:
  - Output sequence is exactly 0..7 with no duplicates or drops; words hold while not ready.
  - FIFO occupancy never exceeds 4.
- `num_passes`=3:
  - Stream is 0..7 repeated three times.
  - With the macro defined, `data_out_last`=1 exactly on each word 7 (three times).
- `num_passes`=0:
  - No `data_out_valid`; `done` pulses at T+2.
  - A second `start` pulse at T+1 is ignored.
- Assert `rst` for one cycle with 5 words delivered and ready=0 during the run:
  - All outputs return to reset values.
  - A subsequent `start` with `num_passes`=1 restarts cleanly at word 0.
- Hold ready=0 for 20 cycles after `start`, then raise it:
  - First 4 words (0..3) are buffered and issue stalls.
  - After ready rises, 0..7 stream out with no gaps beyond the issue restart.
